// File: rtl/speaker_pcm_pkg.sv
// Shared constants and types for the PC speaker to PCM converter.
// The DC-blocked build (SPEAKER_PCM_DCBLOCK_EN) also uses sat_h below.
package speaker_pcm_pkg;

  localparam int SAMPLE_RATE = 48000;
  localparam int FILT_W      = 24;
  localparam int SAMPLE_W    = 16;
  localparam int RATE_W      = 28;

  // Amplitude per volume code: mute, quarter, half, full scale.
  localparam logic [3:0][14:0] VOL_LVL = {15'd32767, 15'd16383, 15'd8191, 15'd0};

  typedef logic signed [SAMPLE_W-1:0] pcm_sample_t;

  // Clamp a widened DC-blocker sum back into the FILT_W-bit state range.
  function automatic logic signed [FILT_W-1:0] sat_h(input logic signed [FILT_W+1:0] v);
    if (v > 26'sd8388607) begin
      return 24'sh7FFFFF;
    end else if (v < -26'sd8388608) begin
      return 24'sh800000;
    end else begin
      return v[FILT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/speaker_dc_block.sv
// First-order DC blocker on the decimated sample stream; state advances only on load.
// The returned sample is combinational from the next state so the top can register it directly.
module speaker_dc_block
  import speaker_pcm_pkg::*;
#(
  parameter int DC_SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] x,
  output logic [15:0] sample
);

  logic signed [FILT_W-1:0] h_reg;
  logic signed [FILT_W-1:0] h_next;
  logic [15:0]              xp_reg;
  logic signed [16:0]       dx;
  logic signed [FILT_W-1:0] leak;
  logic signed [FILT_W+1:0] dx_ext;
  logic signed [FILT_W+1:0] h_ext;
  logic signed [FILT_W+1:0] leak_ext;
  logic signed [FILT_W+1:0] h_wide;

  always_comb begin
    dx       = $signed({1'b0, x}) - $signed({1'b0, xp_reg});
    leak     = h_reg >>> DC_SHIFT;
    dx_ext   = $signed({dx[16], dx, 8'h00});
    h_ext    = $signed({{2{h_reg[FILT_W-1]}}, h_reg});
    leak_ext = $signed({{2{leak[FILT_W-1]}}, leak});
    h_wide   = dx_ext + h_ext - leak_ext;
    h_next   = sat_h(h_wide);
    // Taking the top 16 bits of the clamped state is the saturated h >>> 8.
    sample   = h_next[FILT_W-1:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_reg  <= '0;
      xp_reg <= '0;
    end else if (load) begin
      h_reg  <= h_next;
      xp_reg <= x;
    end
  end

endmodule

// File: rtl/speaker_pcm.sv
// PC speaker square wave -> low-pass -> 48 kHz decimation -> valid/ready PCM output.
// Define SPEAKER_PCM_DCBLOCK_EN to insert the DC blocker in the output stage.
module speaker_pcm
  import speaker_pcm_pkg::*;
#(
  parameter int FILT_SHIFT = 10,
  parameter int DC_SHIFT   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [27:0] clock_rate,
  input  logic        speaker_in,
  input  logic [1:0]  volume,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);

  if (FILT_SHIFT < 1 || FILT_SHIFT > 20) begin : g_bad_filt_shift
    $error("speaker_pcm: FILT_SHIFT must be in 1..20");
  end
  if (DC_SHIFT < 1 || DC_SHIFT > 20) begin : g_bad_dc_shift
    $error("speaker_pcm: DC_SHIFT must be in 1..20");
  end

  logic [RATE_W-1:0]        clock_rate_reg;
  logic [RATE_W-1:0]        acc_reg;
  logic [RATE_W-1:0]        acc_next;
  logic [RATE_W:0]          acc_sum;
  logic                     tick;
  logic                     speaker_reg;
  logic [14:0]              target;
  logic signed [FILT_W:0]   diff;
  logic signed [FILT_W:0]   step;
  logic signed [FILT_W-1:0] y_reg;
  logic signed [FILT_W-1:0] y_next;
  logic [15:0]              x_reg;
  logic                     load_reg;
  logic [15:0]              new_sample;
  logic [15:0]              sample_reg;
  logic                     valid_reg;
  logic                     overrun_reg;

  // One-pole low-pass on the registered speaker level; volume applies combinationally.
  always_comb begin
    target = speaker_reg ? VOL_LVL[volume] : 15'd0;
    diff   = $signed({2'b00, target, 8'h00}) - $signed({y_reg[FILT_W-1], y_reg});
    step   = diff >>> FILT_SHIFT;
    y_next = FILT_W'($signed({y_reg[FILT_W-1], y_reg}) + step);
  end

  // Fractional clock enable; rates at or below SAMPLE_RATE saturate to one tick per clk.
  always_comb begin
    acc_sum  = {1'b0, acc_reg} + (RATE_W+1)'(SAMPLE_RATE);
    tick     = 1'b0;
    acc_next = acc_sum[RATE_W-1:0];
    if (clock_rate_reg == '0) begin
      acc_next = '0;
    end else if (clock_rate_reg <= RATE_W'(SAMPLE_RATE)) begin
      tick     = 1'b1;
      acc_next = '0;
    end else if (acc_sum >= {1'b0, clock_rate_reg}) begin
      tick     = 1'b1;
      acc_next = RATE_W'(acc_sum - {1'b0, clock_rate_reg});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clock_rate_reg <= '0;
      acc_reg        <= '0;
      speaker_reg    <= 1'b0;
      y_reg          <= '0;
      x_reg          <= '0;
      load_reg       <= 1'b0;
    end else begin
      clock_rate_reg <= clock_rate;
      acc_reg        <= acc_next;
      speaker_reg    <= speaker_in;
      y_reg          <= y_next;
      load_reg       <= tick;
      if (tick) begin
        x_reg <= y_reg[FILT_W-1:8];
      end
    end
  end

`ifdef SPEAKER_PCM_DCBLOCK_EN
  logic [15:0] dc_sample;

  speaker_dc_block #(
    .DC_SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_reg),
    .x      (x_reg),
    .sample (dc_sample)
  );

  assign new_sample = dc_sample;
`else
  assign new_sample = x_reg;
`endif

  // A load always wins over a consume; overwriting an unconsumed sample flags overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_reg  <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (load_reg) begin
        sample_reg  <= new_sample;
        valid_reg   <= 1'b1;
        overrun_reg <= valid_reg && !sample_ready;
      end else if (valid_reg && sample_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign sample_out   = sample_reg;
  assign sample_valid = valid_reg;
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_speaker_pcm.sv
// Directed bench for speaker_pcm at clock_rate = 480000 (one tick per 10 clk).
module tb_speaker_pcm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] clock_rate;
  logic        speaker_in;
  logic [1:0]  volume;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // Volume 1 from reset: y after edge 10 is 18351 (>>8 = 71), after edge 20 is 38554 (>>8 = 150).
  localparam int EXP_S1 = 71;
`ifdef SPEAKER_PCM_DCBLOCK_EN
  localparam int EXP_S2 = 149;
`else
  localparam int EXP_S2 = 150;
`endif

  speaker_pcm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clock_rate   (clock_rate),
    .speaker_in   (speaker_in),
    .volume       (volume),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] vol, input logic spk, input logic rdy);
    rst_n        = 1'b0;
    clock_rate   = 28'd480000;
    volume       = vol;
    speaker_in   = spk;
    sample_ready = rdy;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    clock_rate   = 28'd480000;
    volume       = 2'd3;
    speaker_in   = 1'b1;
    sample_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sample_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_sample: got %0d expected 0", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", sample_valid);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_overrun: got %b expected 0", overrun);
    end
    $display("test_reset done: sample=%0d valid=%b overrun=%b", sample_out, sample_valid, overrun);
  endtask

  task automatic test_tick_spacing();
    logic exp_v;
    do_reset(2'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 60; k++) begin
      step();
      exp_v = (k >= 12) && (((k - 12) % 10) == 0);
      checks++;
      if (sample_valid !== exp_v) begin
        errors++;
        $display("FAIL tick_valid edge %0d: got %b expected %b", k, sample_valid, exp_v);
      end
      checks++;
      if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL tick_overrun edge %0d: got %b expected 0", k, overrun);
      end
    end
    $display("test_tick_spacing done");
  endtask

  task automatic test_overrun();
    do_reset(2'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      if (k == 11) begin
        checks++;
        if (sample_valid !== 1'b0) begin
          errors++;
          $display("FAIL ovr_pre_valid: got %b expected 0", sample_valid);
        end
      end
      if (k == 12 || k == 21) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_out !== 16'(EXP_S1)) begin
          errors++;
          $display("FAIL ovr_first edge %0d: got valid=%b ovr=%b sample=%0d expected 1 0 %0d",
                   k, sample_valid, overrun, sample_out, EXP_S1);
        end
      end
      if (k == 22) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b1 || sample_out !== 16'(EXP_S2)) begin
          errors++;
          $display("FAIL ovr_second: got valid=%b ovr=%b sample=%0d expected 1 1 %0d",
                   sample_valid, overrun, sample_out, EXP_S2);
        end
      end
      if (k == 23) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ovr_pulse_end: got valid=%b ovr=%b expected 1 0", sample_valid, overrun);
        end
        sample_ready = 1'b1;
      end
      if (k == 24) begin
        checks++;
        if (sample_valid !== 1'b0 || sample_out !== 16'(EXP_S2)) begin
          errors++;
          $display("FAIL ovr_consume: got valid=%b sample=%0d expected 0 %0d",
                   sample_valid, sample_out, EXP_S2);
        end
        sample_ready = 1'b0;
      end
      if (k == 32) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL ovr_reload: got valid=%b ovr=%b expected 1 0", sample_valid, overrun);
        end
      end
    end
    $display("test_overrun done: last sample=%0d", sample_out);
  endtask

  task automatic test_back_to_back();
    do_reset(2'd1, 1'b1, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 12) begin
        checks++;
        if (sample_valid !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first_valid: got %b expected 1", sample_valid);
        end
      end
      if (k == 21) begin
        sample_ready = 1'b1;
      end
      if (k == 22) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0 || sample_out !== 16'(EXP_S2)) begin
          errors++;
          $display("FAIL b2b_load_consume: got valid=%b ovr=%b sample=%0d expected 1 0 %0d",
                   sample_valid, overrun, sample_out, EXP_S2);
        end
      end
      if (k == 23 || k == 33) begin
        checks++;
        if (sample_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_drop edge %0d: got %b expected 0", k, sample_valid);
        end
      end
      if (k == 32) begin
        checks++;
        if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL b2b_next_load: got valid=%b ovr=%b expected 1 0", sample_valid, overrun);
        end
      end
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_mute();
    int nvalid = 0;
    do_reset(2'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 600; k++) begin
      step();
      if ((k % 50) == 0) begin
        speaker_in = ~speaker_in;
      end
      checks++;
      if (overrun !== 1'b0) begin
        errors++;
        $display("FAIL mute_overrun edge %0d: got %b expected 0", k, overrun);
      end
      if (sample_valid === 1'b1) begin
        nvalid++;
        checks++;
        if (sample_out !== 16'd0) begin
          errors++;
          $display("FAIL mute_sample edge %0d: got %0d expected 0", k, sample_out);
        end
      end
    end
    checks++;
    if (nvalid != 59) begin
      errors++;
      $display("FAIL mute_count: got %0d samples expected 59", nvalid);
    end
    $display("test_mute done: %0d samples", nvalid);
  endtask

`ifndef SPEAKER_PCM_DCBLOCK_EN
  task automatic test_filter();
    do_reset(2'd3, 1'b1, 1'b1);
    repeat (14000) step();
    checks++;
    if (sample_out < 16'd32763 || sample_out > 16'd32767) begin
      errors++;
      $display("FAIL filt_full: got %0d expected 32763..32767", sample_out);
    end
    $display("test_filter full-scale sample=%0d", sample_out);
    speaker_in = 1'b0;
    repeat (14000) step();
    checks++;
    if (sample_out > 16'd7) begin
      errors++;
      $display("FAIL filt_decay: got %0d expected <= 7", sample_out);
    end
    $display("test_filter decayed sample=%0d", sample_out);
    volume     = 2'd1;
    speaker_in = 1'b1;
    repeat (14000) step();
    checks++;
    if (sample_out < 16'd8187 || sample_out > 16'd8191) begin
      errors++;
      $display("FAIL filt_vol1: got %0d expected 8187..8191", sample_out);
    end
    $display("test_filter vol1 sample=%0d", sample_out);
    volume = 2'd2;
    repeat (12000) step();
    checks++;
    if (sample_out < 16'd16379 || sample_out > 16'd16383) begin
      errors++;
      $display("FAIL filt_vol2: got %0d expected 16379..16383", sample_out);
    end
    $display("test_filter vol2 sample=%0d", sample_out);
  endtask
`else
  task automatic test_dcblock();
    int mag;
    do_reset(2'd3, 1'b1, 1'b1);
    repeat (41000) step();
    mag = $signed(sample_out);
    if (mag < 0) mag = -mag;
    checks++;
    if (mag >= 256) begin
      errors++;
      $display("FAIL dc_decay: got %0d expected |x| < 256", $signed(sample_out));
    end
    $display("test_dcblock sample=%0d", $signed(sample_out));
  endtask
`endif

  task automatic test_midstream_reset();
    logic found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      found = (sample_valid === 1'b1);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_wait_valid: no sample within 20 clk");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample_out !== 16'd0 || sample_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got sample=%0d valid=%b ovr=%b expected 0 0 0",
               sample_out, sample_valid, overrun);
    end
    $display("test_midstream_reset done: sample=%0d valid=%b", sample_out, sample_valid);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tick_spacing();
    test_overrun();
    test_back_to_back();
    test_mute();
`ifndef SPEAKER_PCM_DCBLOCK_EN
    test_filter();
`else
    test_dcblock();
`endif
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
